// File: rtl/sift_pkg.sv
// sift_pkg: shared keypoint-streamer FSM states and frame delimiter bytes.
package sift_pkg;
  typedef enum logic [3:0] {
    IDLE, HDR, CNT_HI, CNT_LO, FETCH, WAIT1, WAIT2, SX, SY, SL, TRL, FIN
  } state_t;
  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] TRL_BYTE = 8'h5A;
endpackage

// File: rtl/keypoint_streamer.sv
// keypoint_streamer: reads keypoints from an external 2-cycle BRAM and frames them as a byte stream.
module keypoint_streamer
  import sift_pkg::*;
#(
  parameter int DIMENSION = 4,
  parameter int KW = 2*$clog2(DIMENSION)+1
) (
  input  logic                                   clk,
  input  logic                                   rst_in,
  input  logic                                   start,
  input  logic [$clog2(DIMENSION*DIMENSION):0]   num_keypts,
  output logic [$clog2(DIMENSION*DIMENSION)-1:0] key_read_addr,
  input  logic [KW-1:0]                          key_data,
  output logic [7:0]                             out_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic                                   done
);
  localparam int CW = $clog2(DIMENSION);
  localparam int AW = $clog2(DIMENSION*DIMENSION);
  localparam int NW = AW + 1;
  localparam logic [NW-1:0] MAXK = NW'(DIMENSION*DIMENSION);
  state_t state_q, state_d;
  logic [NW-1:0] count_q, index_q, idx_inc;
  logic [AW-1:0] addr_q;
  logic [KW-1:0] key_q;
  logic [15:0]   count16;
  logic          xfer;
  assign idx_inc = index_q + 1'b1;
  assign count16 = 16'(count_q);
  assign xfer    = out_valid && out_ready;
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      addr_q  <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        count_q <= (num_keypts > MAXK) ? MAXK : num_keypts;
        index_q <= '0;
      end
      if (state_q == FETCH) addr_q <= index_q[AW-1:0];
      if (state_q == WAIT2) key_q <= key_data;
      if (state_q == SL && xfer) index_q <= idx_inc;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? HDR : IDLE;
      HDR:     state_d = xfer ? CNT_HI : HDR;
      CNT_HI:  state_d = xfer ? CNT_LO : CNT_HI;
      CNT_LO:  state_d = xfer ? ((count_q != '0) ? FETCH : TRL) : CNT_LO;
      FETCH:   state_d = WAIT1;
      WAIT1:   state_d = WAIT2;
      WAIT2:   state_d = SX;
      SX:      state_d = xfer ? SY : SX;
      SY:      state_d = xfer ? SL : SY;
      SL:      state_d = xfer ? ((idx_inc < count_q) ? FETCH : TRL) : SL;
      TRL:     state_d = xfer ? FIN : TRL;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Byte mux depends only on registered state, so out_data cannot move during a stall.
  always_comb begin
    out_valid     = state_q inside {HDR, CNT_HI, CNT_LO, SX, SY, SL, TRL};
    key_read_addr = (state_q == FETCH) ? index_q[AW-1:0] : addr_q;
    busy          = state_q != IDLE;
    done          = state_q == FIN;
    case (state_q)
      HDR:     out_data = HDR_BYTE;
      CNT_HI:  out_data = count16[15:8];
      CNT_LO:  out_data = count16[7:0];
      SX:      out_data = 8'(key_q[KW-1 -: CW]);
      SY:      out_data = 8'(key_q[CW:1]);
      SL:      out_data = {7'b0, key_q[0]};
      TRL:     out_data = TRL_BYTE;
      default: out_data = 8'h00;
    endcase
  end
endmodule
